bp_me_mmio_responder: RTL

//  Synthesizable BedRock uncached-memory responder: the endpoint that answers
//  io_cmd traffic issued by an initiator such as the nbf loader.

---
 rtl/bp_me_mmio_pkg.sv | 38 +++
 rtl/bp_me_mmio_regfile.sv | 48 ++++
 rtl/bp_me_mmio_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bp_me_mmio_pkg.sv
// Shared definitions for the BedRock MMIO responder.
// Holds the register-map offsets (low 16 address bits), the responder FSM
// state type, the subset of BedRock memory command types the responder
// recognises, and the byte-mask helper used for sized scratch writes.
package bp_me_mmio_pkg;

    // Region selectors compare offset[15:12]; single-register targets compare all 16 bits.
    localparam logic [3:0]  finish_region_gp  = 4'h0;
    localparam logic [15:0] putchar_addr_gp   = 16'h1000;
    localparam logic [3:0]  scratch_region_gp = 4'h2;
    localparam logic [15:0] counter_addr_gp   = 16'h3000;

    typedef enum logic [1:0] {
        e_idle,
        e_wait,
        e_resp
    } bp_me_mmio_state_e;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    // Mask covering the low 2^size bytes of a 64-bit word.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bp_me_mmio_regfile.sv
// Scratch register array and free-running cycle counter for the MMIO responder.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset (clears scratch and counter)
//   wr_v_i          write strobe for scratch[wr_idx_i]
//   wr_idx_i        scratch write index
//   wr_size_i       log2 bytes written; upper bytes of the register are kept
//   wr_data_i       LSB-justified write data
//   rd_idx_i        scratch read index
//   rd_data_o       combinational read of scratch[rd_idx_i]
//   count_o         64-bit cycle counter, +1 every non-reset cycle, wraps
module bp_me_mmio_regfile
    import bp_me_mmio_pkg::*;
#(
    parameter int num_scratch_p = 8,
    parameter int idx_width_p   = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   wr_v_i,
    input  logic [idx_width_p-1:0] wr_idx_i,
    input  logic [1:0]             wr_size_i,
    input  logic [63:0]            wr_data_i,
    input  logic [idx_width_p-1:0] rd_idx_i,
    output logic [63:0]            rd_data_o,
    output logic [63:0]            count_o
);

    logic [63:0] scratch [num_scratch_p];
    logic [63:0] mask;

    assign mask      = size_mask(wr_size_i);
    assign rd_data_o = scratch[rd_idx_i];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_scratch_p; i++) begin
                scratch[i] <= '0;
            end
            count_o <= '0;
        end else begin
            count_o <= count_o + 64'd1;
            if (wr_v_i) begin
                scratch[wr_idx_i] <= (scratch[wr_idx_i] & ~mask) | (wr_data_i & mask);
            end
        end
    end

endmodule

// File: rtl/bp_me_mmio_responder.sv
// BedRock uncached-memory responder: accepts one io_cmd at a time, decodes it
// against a small MMIO map (finish flags, putchar, scratch, cycle counter),
// applies side effects and captures read data on the accept edge, and returns
// the response latency_p cycles later, holding it until resp_yumi_i.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   cmd_*_i, cmd_v_i      command header/data and valid
//   cmd_ready_o           high only while idle; accept = cmd_v_i & cmd_ready_o
//   resp_*_o, resp_v_o    echoed header plus read data, valid until yumi
//   resp_yumi_i           consumer takes the response
//   finish_o              sticky per-core finish flags
//   char_o, char_v_o      putchar byte and its one-cycle strobe
//   error_o               sticky flag for unmapped address or illegal type/size
module bp_me_mmio_responder
    import bp_me_mmio_pkg::*;
#(
    parameter int paddr_width_p   = 40,
    parameter int data_width_p    = 64,
    parameter int payload_width_p = 16,
    parameter int num_core_p      = 4,
    parameter int num_scratch_p   = 8,
    parameter int latency_p       = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [3:0]                 cmd_type_i,
    input  logic [paddr_width_p-1:0]   cmd_addr_i,
    input  logic [2:0]                 cmd_size_i,
    input  logic [payload_width_p-1:0] cmd_payload_i,
    input  logic [data_width_p-1:0]    cmd_data_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    output logic [3:0]                 resp_type_o,
    output logic [paddr_width_p-1:0]   resp_addr_o,
    output logic [2:0]                 resp_size_o,
    output logic [payload_width_p-1:0] resp_payload_o,
    output logic [data_width_p-1:0]    resp_data_o,
    output logic                       resp_v_o,
    input  logic                       resp_yumi_i,
    output logic [num_core_p-1:0]      finish_o,
    output logic [7:0]                 char_o,
    output logic                       char_v_o,
    output logic                       error_o
);

    localparam int scratch_idx_w_lp = (num_scratch_p > 1) ? $clog2(num_scratch_p) : 1;
    localparam int core_idx_w_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int cnt_w_lp         = (latency_p > 1) ? $clog2(latency_p) : 1;

    bp_me_mmio_state_e       state;
    logic [cnt_w_lp-1:0]     wait_cnt;
    logic                    accept;
    logic [15:0]             offset;
    logic                    unused_upper_addr;

    logic                    is_rd, is_wr, size_ok, aligned;
    logic                    hit_finish, hit_putchar, hit_scratch, hit_counter, mapped;
    logic                    bad_cmd;
    logic [data_width_p-1:0] rd_value;

    logic [63:0]             rf_rd_data;
    logic [63:0]             count;
    logic                    rf_wr_v;

    assign accept = cmd_v_i & cmd_ready_o;
    assign offset = cmd_addr_i[15:0];
    // Address bits above the 64 KiB window are deliberately ignored.
    assign unused_upper_addr = ^cmd_addr_i[paddr_width_p-1:16];

    always_comb begin
        is_rd       = (cmd_type_i == e_bedrock_mem_rd) || (cmd_type_i == e_bedrock_mem_uc_rd);
        is_wr       = (cmd_type_i == e_bedrock_mem_wr) || (cmd_type_i == e_bedrock_mem_uc_wr);
        size_ok     = (cmd_size_i <= 3'd3);
        aligned     = (offset[2:0] == 3'b000);
        // Indexed regions need 8-byte aligned slots below the configured count.
        hit_finish  = size_ok && aligned && (offset[15:12] == finish_region_gp)
                      && (int'(offset[11:3]) < num_core_p);
        hit_scratch = size_ok && aligned && (offset[15:12] == scratch_region_gp)
                      && (int'(offset[11:3]) < num_scratch_p);
        hit_putchar = size_ok && (offset == putchar_addr_gp);
        hit_counter = size_ok && (offset == counter_addr_gp);
        mapped      = hit_finish || hit_scratch || hit_putchar || hit_counter;
        bad_cmd     = !(is_rd || is_wr) || !mapped;

        rd_value = '0;
        if (is_rd) begin
            if (hit_finish) begin
                rd_value = data_width_p'(finish_o);
            end else if (hit_scratch) begin
                rd_value = data_width_p'(rf_rd_data);
            end else if (hit_counter) begin
                rd_value = data_width_p'(count);
            end
        end
    end

    assign rf_wr_v = accept && is_wr && hit_scratch;

    bp_me_mmio_regfile #(
        .num_scratch_p (num_scratch_p),
        .idx_width_p   (scratch_idx_w_lp)
    ) regfile (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_v_i    (rf_wr_v),
        .wr_idx_i  (offset[3 +: scratch_idx_w_lp]),
        .wr_size_i (cmd_size_i[1:0]),
        .wr_data_i (64'(cmd_data_i)),
        .rd_idx_i  (offset[3 +: scratch_idx_w_lp]),
        .rd_data_o (rf_rd_data),
        .count_o   (count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= e_idle;
            wait_cnt    <= '0;
            cmd_ready_o <= 1'b0;
            resp_v_o    <= 1'b0;
            finish_o    <= '0;
            char_o      <= '0;
            char_v_o    <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            char_v_o <= 1'b0;
            case (state)
                e_idle: begin
                    cmd_ready_o <= 1'b1;
                    if (accept) begin
                        state       <= e_wait;
                        cmd_ready_o <= 1'b0;
                        wait_cnt    <= '0;
                        if (bad_cmd) begin
                            error_o <= 1'b1;
                        end
                        if (is_wr && hit_finish && cmd_data_i[0]) begin
                            finish_o[offset[3 +: core_idx_w_lp]] <= 1'b1;
                        end
                        if (is_wr && hit_putchar) begin
                            char_o   <= cmd_data_i[7:0];
                            char_v_o <= 1'b1;
                        end
                    end
                end
                e_wait: begin
                    // Counter started at 0 on the accept edge, so reaching
                    // latency_p-1 puts resp_v_o exactly latency_p edges later.
                    if (wait_cnt == cnt_w_lp'(latency_p - 1)) begin
                        state    <= e_resp;
                        resp_v_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                e_resp: begin
                    if (resp_yumi_i) begin
                        state       <= e_idle;
                        resp_v_o    <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= e_idle;
                    cmd_ready_o <= 1'b0;
                    resp_v_o    <= 1'b0;
                end
            endcase
        end
    end

    // Response header and data are captured once and held through RESP.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            resp_type_o    <= cmd_type_i;
            resp_addr_o    <= cmd_addr_i;
            resp_size_o    <= cmd_size_i;
            resp_payload_o <= cmd_payload_i;
            resp_data_o    <= rd_value;
        end
    end

endmodule
